// File: rtl/dp_exec_ctrl.sv
// dp_exec_ctrl: multi-cycle control/execute stage for ARM data-processing
// instructions. Paces the fetch stage, decodes the latched instruction,
// forms operand2 with a barrel shifter, drives the external ALU, writes
// back Rd and maintains the architectural NZCV flags.
// Optional feature macro: DP_REG_SHIFT_EN (register-specified shifts via port C).
module dp_exec_ctrl #(
  parameter logic [3:0]  NZCV_INIT  = 4'b0000,
  parameter int unsigned FETCH_WAIT = 1
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [28:1] IR,
  input  logic        flag,
  input  logic [31:0] R_Data_A,
  input  logic [31:0] R_Data_B,
  input  logic [31:0] R_Data_C,
  input  logic [31:0] ALU_F,
  input  logic [4:1]  ALU_NZCV,
  output logic        Write_IR,
  output logic        Write_PC,
  output logic [3:0]  r_addr_A,
  output logic [3:0]  r_addr_B,
  output logic [3:0]  r_addr_C,
  output logic [3:0]  w_addr,
  output logic        Write_Reg,
  output logic [31:0] W_Data,
  output logic [3:0]  ALU_OP,
  output logic [31:0] ALU_A,
  output logic [31:0] ALU_B,
  output logic [4:1]  NZCV
);

  localparam int unsigned WW = (FETCH_WAIT > 2) ? $clog2(FETCH_WAIT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_DEC, S_EXE, S_WB} state_t;
  typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shift_t;

  state_t         state, nxt;
  logic [WW-1:0]  wait_cnt;
  logic [27:0]    b;
  logic [31:0]    op_a, op_b;
  logic [7:0]     amt;
  logic [4:1]     alu_flags;
  logic           sh_c, sh_c_q, c_in;
  logic           is_dp, reg_shift, exec_ok, arith, no_wb;
  shift_t         sh_type;
  logic [4:0]     sh5, rot;
  logic [31:0]    imm32;
  logic [32:0]    lsl_w, lsr_w, asr_w;
  logic [63:0]    ror_w, imm_w;

  // Instruction bit n sits on IR[n+1]
  assign b         = IR;
  assign r_addr_A  = b[19:16];
  assign r_addr_B  = b[3:0];
  assign w_addr    = b[15:12];
  assign ALU_OP    = b[24:21];
  assign ALU_A     = op_a;
  assign c_in      = NZCV[2];

  assign is_dp     = (b[27:26] == 2'b00);
  assign reg_shift = !b[25] && b[4];
  assign arith     = (ALU_OP[3:2] == 2'b01) || (ALU_OP[3:1] == 3'b001) ||
                     (ALU_OP[3:1] == 3'b101);
  assign no_wb     = (ALU_OP[3:2] == 2'b10);

`ifdef DP_REG_SHIFT_EN
  logic [7:0] op_c;
  logic       unused_rs_hi;
  assign r_addr_C     = b[11:8];
  assign exec_ok      = flag && is_dp;
  assign amt          = b[4] ? op_c : {3'b000, b[11:7]};
  assign unused_rs_hi = ^R_Data_C[31:8];
`else
  logic unused_rs;
  assign r_addr_C  = '0;
  assign exec_ok   = flag && is_dp && !reg_shift;
  assign amt       = {3'b000, b[11:7]};
  assign unused_rs = ^R_Data_C;
`endif

  // Shift candidates; a guard bit beside Rm carries the shifter carry-out
  assign sh_type = shift_t'(b[6:5]);
  assign sh5     = amt[4:0];
  assign rot     = {b[11:8], 1'b0};
  assign imm32   = {24'h000000, b[7:0]};
  assign lsl_w   = {1'b0, op_b} << sh5;
  assign lsr_w   = {op_b, 1'b0} >> sh5;
  assign asr_w   = 33'($signed({op_b, 1'b0}) >>> sh5);
  assign ror_w   = {op_b, op_b} >> sh5;
  assign imm_w   = {imm32, imm32} >> rot;

  // State register and fetch-wait counter
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= nxt;
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    nxt       = state;
    Write_IR  = 1'b0;
    Write_PC  = 1'b0;
    Write_Reg = 1'b0;
    case (state)
      S_IDLE:  nxt = S_FETCH;
      S_FETCH: begin
        Write_IR = 1'b1;
        Write_PC = 1'b1;
        nxt      = (FETCH_WAIT == 0) ? S_DEC : S_WAIT;
      end
      S_WAIT:  if (wait_cnt == WW'(FETCH_WAIT - 1)) nxt = S_DEC;
      S_DEC:   nxt = exec_ok ? S_EXE : S_FETCH;
      S_EXE:   nxt = S_WB;
      S_WB: begin
        Write_Reg = !no_wb;
        nxt       = S_FETCH;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Operand2 barrel shifter with carry-out
  always_comb begin
    ALU_B = op_b;
    sh_c  = c_in;
    if (b[25]) begin
      ALU_B = imm_w[31:0];
      sh_c  = (b[11:8] == 4'h0) ? c_in : imm_w[31];
    end else if (amt == 8'd0) begin
      // Immediate amount 0 encodes LSR/ASR #32 and RRX; register amount 0 is a pass-through
      if (!b[4]) begin
        case (sh_type)
          SH_LSR: begin ALU_B = '0;               sh_c = op_b[31]; end
          SH_ASR: begin ALU_B = {32{op_b[31]}};   sh_c = op_b[31]; end
          SH_ROR: begin ALU_B = {c_in, op_b[31:1]}; sh_c = op_b[0]; end
          default: ;
        endcase
      end
    end else begin
      case (sh_type)
        SH_LSL: begin
          if (amt < 8'd32)       begin ALU_B = lsl_w[31:0]; sh_c = lsl_w[32]; end
          else if (amt == 8'd32) begin ALU_B = '0;          sh_c = op_b[0];   end
          else                   begin ALU_B = '0;          sh_c = 1'b0;      end
        end
        SH_LSR: begin
          if (amt < 8'd32)       begin ALU_B = lsr_w[32:1]; sh_c = lsr_w[0];  end
          else if (amt == 8'd32) begin ALU_B = '0;          sh_c = op_b[31];  end
          else                   begin ALU_B = '0;          sh_c = 1'b0;      end
        end
        SH_ASR: begin
          if (amt < 8'd32) begin ALU_B = asr_w[32:1];     sh_c = asr_w[0];  end
          else             begin ALU_B = {32{op_b[31]}};  sh_c = op_b[31];  end
        end
        default: begin
          ALU_B = ror_w[31:0];
          sh_c  = ror_w[31];
        end
      endcase
    end
  end

  // Operand latches, ALU result capture and flag update
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      op_a      <= '0;
      op_b      <= '0;
`ifdef DP_REG_SHIFT_EN
      op_c      <= '0;
`endif
      W_Data    <= '0;
      alu_flags <= '0;
      sh_c_q    <= 1'b0;
      NZCV      <= NZCV_INIT;
    end else begin
      case (state)
        S_DEC: begin
          op_a <= R_Data_A;
          op_b <= R_Data_B;
`ifdef DP_REG_SHIFT_EN
          op_c <= R_Data_C[7:0];
`endif
        end
        S_EXE: begin
          W_Data    <= ALU_F;
          alu_flags <= ALU_NZCV;
          sh_c_q    <= sh_c;
        end
        S_WB: begin
          if (b[20])
            NZCV <= {alu_flags[4], alu_flags[3],
                     arith ? alu_flags[2] : sh_c_q,
                     arith ? alu_flags[1] : NZCV[1]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_exec_ctrl.sv
// Bench for dp_exec_ctrl: models the fetch stage, register file and ALU,
// and scores each instruction at the following fetch.
module tb_dp_exec_ctrl;

  localparam int unsigned FW   = 1;
  localparam logic [3:0]  INIT = 4'b0010;
  localparam int unsigned EXE  = 4 + FW;
  localparam int unsigned SKP  = 2 + FW;

  logic        clk, Rst, flag;
  logic [28:1] IR;
  logic [31:0] R_Data_A, R_Data_B, R_Data_C, ALU_F;
  logic [4:1]  ALU_NZCV;
  logic        Write_IR, Write_PC, Write_Reg;
  logic [3:0]  r_addr_A, r_addr_B, r_addr_C, w_addr, ALU_OP;
  logic [31:0] W_Data, ALU_A, ALU_B;
  logic [4:1]  NZCV;

  logic [31:0] rf [16];
  int unsigned n_checks = 0, n_err = 0;
  int unsigned cyc = 0, wr_cnt = 0, t_fetch = 0;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;

  typedef struct {
    logic [27:0] ir; logic flg; logic we; logic [3:0] wa;
    logic [31:0] wd; logic [3:0] nz; int unsigned lat;
  } entry_t;
  entry_t prog[$];
  entry_t sb[$];

  dp_exec_ctrl #(.NZCV_INIT(INIT), .FETCH_WAIT(FW)) u_dut (
    .clk(clk), .Rst(Rst), .IR(IR), .flag(flag),
    .R_Data_A(R_Data_A), .R_Data_B(R_Data_B), .R_Data_C(R_Data_C),
    .ALU_F(ALU_F), .ALU_NZCV(ALU_NZCV),
    .Write_IR(Write_IR), .Write_PC(Write_PC),
    .r_addr_A(r_addr_A), .r_addr_B(r_addr_B), .r_addr_C(r_addr_C),
    .w_addr(w_addr), .Write_Reg(Write_Reg), .W_Data(W_Data),
    .ALU_OP(ALU_OP), .ALU_A(ALU_A), .ALU_B(ALU_B), .NZCV(NZCV)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign R_Data_A = rf[r_addr_A];
  assign R_Data_B = rf[r_addr_B];
  assign R_Data_C = rf[r_addr_C];

  // Reference ALU; logical ops report C=0/V=0 so the stage must use its own carry
  logic [32:0] s;
  logic        av;
  always_comb begin
    s  = '0;
    av = 1'b0;
    case (ALU_OP)
      4'h0, 4'h8: s = {1'b0, ALU_A & ALU_B};
      4'h1, 4'h9: s = {1'b0, ALU_A ^ ALU_B};
      4'h2, 4'hA: begin s = {1'b0, ALU_A} + {1'b0, ~ALU_B} + 33'd1;
                  av = (ALU_A[31] != ALU_B[31]) && (s[31] != ALU_A[31]); end
      4'h3:       begin s = {1'b0, ALU_B} + {1'b0, ~ALU_A} + 33'd1;
                  av = (ALU_A[31] != ALU_B[31]) && (s[31] != ALU_B[31]); end
      4'h4, 4'hB: begin s = {1'b0, ALU_A} + {1'b0, ALU_B};
                  av = (ALU_A[31] == ALU_B[31]) && (s[31] != ALU_A[31]); end
      4'h5:       begin s = {1'b0, ALU_A} + {1'b0, ALU_B} + {32'd0, NZCV[2]};
                  av = (ALU_A[31] == ALU_B[31]) && (s[31] != ALU_A[31]); end
      4'h6:       begin s = {1'b0, ALU_A} + {1'b0, ~ALU_B} + {32'd0, NZCV[2]};
                  av = (ALU_A[31] != ALU_B[31]) && (s[31] != ALU_A[31]); end
      4'h7:       begin s = {1'b0, ALU_B} + {1'b0, ~ALU_A} + {32'd0, NZCV[2]};
                  av = (ALU_A[31] != ALU_B[31]) && (s[31] != ALU_B[31]); end
      4'hC:       s = {1'b0, ALU_A | ALU_B};
      4'hD:       s = {1'b0, ALU_B};
      4'hE:       s = {1'b0, ALU_A & ~ALU_B};
      default:    s = {1'b0, ~ALU_B};
    endcase
  end
  assign ALU_F    = s[31:0];
  assign ALU_NZCV = {s[31], s[31:0] == 32'd0, s[32], av};

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (Write_Reg === 1'b1) rf[w_addr] <= W_Data;
  always @(negedge clk) if (Write_Reg === 1'b1) begin
    wr_cnt  = wr_cnt + 1;
    wr_addr = w_addr;
    wr_data = W_Data;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic wait_fetch(output bit ok);
    int unsigned n = 0;
    ok = 1'b0;
    while (!ok && n < 40) begin
      @(negedge clk);
      n++;
      if (Write_IR === 1'b1) ok = 1'b1;
    end
    if (!ok) check_eq("fetch_timeout", {31'd0, Write_IR}, 32'd1);
  endtask

  initial begin
    entry_t e;
    bit ok;
    for (int i = 0; i < 16; i++) rf[i] = 32'h1000_0000 + i;
    rf[2] = 32'h7FFF_FF01; rf[3] = 32'h8000_0000; rf[4] = 32'h0000_0055;
    rf[6] = 32'h1234_5678; rf[7] = 32'h0000_0020;
    Rst = 1'b0; IR = '0; flag = 1'b0;

    // ADDS R1,R2,#0xFF
    prog.push_back('{28'h29210FF, 1'b1, 1'b1, 4'd1, 32'h8000_0000, 4'b1001, EXE});
    // MOVS R0,R3,LSR #0 (LSR #32): C=Rm[31], V kept
    prog.push_back('{28'h1B00023, 1'b1, 1'b1, 4'd0, 32'h0000_0000, 4'b0111, EXE});
    // CMP R4,R4: no write-back
    prog.push_back('{28'h1540004, 1'b1, 1'b0, 4'd0, 32'h0,         4'b0110, EXE});
    // ADDS with failed condition
    prog.push_back('{28'h29210FF, 1'b0, 1'b0, 4'd0, 32'h0,         4'b0110, SKP});
`ifdef DP_REG_SHIFT_EN
    // MOV R5,R6,ROR R7 (R7=32)
    prog.push_back('{28'h1A05776, 1'b1, 1'b1, 4'd5, 32'h1234_5678, 4'b0110, EXE});
`else
    prog.push_back('{28'h1A05776, 1'b1, 1'b0, 4'd0, 32'h0,         4'b0110, SKP});
`endif
    // Non data-processing class
    prog.push_back('{28'h4000000, 1'b1, 1'b0, 4'd0, 32'h0,         4'b0110, SKP});
    // MOVS R8,#0x02 ror 2: C=result[31]
    prog.push_back('{28'h3B08102, 1'b1, 1'b1, 4'd8, 32'h8000_0000, 4'b1010, EXE});
    // ADD R15,R2,#1: ordinary write, flags kept
    prog.push_back('{28'h282F001, 1'b1, 1'b1, 4'd15, 32'h7FFF_FF02, 4'b1010, EXE});
    // MOVS R9,R3,ASR #4
    prog.push_back('{28'h1B09243, 1'b1, 1'b1, 4'd9, 32'hF800_0000, 4'b1000, EXE});
    // TST R2,#0: no write, C from shifter (unrotated imm keeps C)
    prog.push_back('{28'h3120000, 1'b1, 1'b0, 4'd0, 32'h0,         4'b0100, EXE});
    prog.push_back('{28'h0000000, 1'b0, 1'b0, 4'd0, 32'h0,         4'b0100, SKP});

    repeat (3) @(negedge clk);
    check_eq("rst_write_ir",  {31'd0, Write_IR},  32'd0);
    check_eq("rst_write_pc",  {31'd0, Write_PC},  32'd0);
    check_eq("rst_write_reg", {31'd0, Write_Reg}, 32'd0);
    check_eq("rst_nzcv",      {28'd0, NZCV},      {28'd0, INIT});
    check_eq("rst_w_data",    W_Data,             32'd0);
    check_eq("rst_alu_a",     ALU_A,              32'd0);
    Rst = 1'b1;

    wait_fetch(ok);
    t_fetch = cyc;
    wr_cnt  = 0;
    foreach (prog[i]) begin
      if (!ok) break;
      e = prog[i];
      check_eq("write_pc", {31'd0, Write_PC}, 32'd1);
      @(posedge clk);
      #1 IR = e.ir; flag = e.flg;
      sb.push_back(e);
      @(negedge clk);
      check_eq("ir_one_cycle", {31'd0, Write_IR}, 32'd0);
      wait_fetch(ok);
      if (ok && sb.size() > 0) begin
        e = sb.pop_front();
        check_eq($sformatf("lat%0d", i),  cyc - t_fetch, e.lat);
        check_eq($sformatf("wcnt%0d", i), wr_cnt, {31'd0, e.we});
        if (e.we) begin
          check_eq($sformatf("waddr%0d", i), {28'd0, wr_addr}, {28'd0, e.wa});
          check_eq($sformatf("wdata%0d", i), wr_data, e.wd);
        end
        check_eq($sformatf("nzcv%0d", i), {28'd0, NZCV}, {28'd0, e.nz});
        t_fetch = cyc;
        wr_cnt  = 0;
      end
    end

    // Reset in the middle of S_EXE of an ADDS
    if (ok) begin
      @(posedge clk);
      #1 IR = 28'h29210FF; flag = 1'b1;
      repeat (FW + 1) @(posedge clk);
      #2 Rst = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_nzcv",  {28'd0, NZCV}, {28'd0, INIT});
      check_eq("mid_rst_alu_a", ALU_A, 32'd0);
      check_eq("mid_rst_wreg",  {31'd0, Write_Reg}, 32'd0);
      repeat (2) @(negedge clk);
      Rst = 1'b1;
      #1 check_eq("rel_idle", {31'd0, Write_IR}, 32'd0);
      @(negedge clk);
      check_eq("rel_fetch", {31'd0, Write_IR}, 32'd1);
      check_eq("rel_no_wr", wr_cnt, 32'd0);
      check_eq("rel_nzcv",  {28'd0, NZCV}, {28'd0, INIT});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
